// File: rtl/typer_pkg.sv
// Shared definitions for the typing-game statistics path.
// Game-state codes, commit FSM encoding and default widths.
package typer_pkg;
    localparam int DATA_W_DEF = 10;
    localparam int CNT_W_DEF  = 4;

    localparam logic [2:0] GS_TYPING = 3'd2;
    localparam logic [2:0] GS_RESULT = 3'd3;

    typedef enum logic [2:0] {
        C_IDLE    = 3'd0,
        C_LATCH   = 3'd1,
        C_DIV_WPM = 3'd2,
        C_DIV_ACC = 3'd3,
        C_WRITE   = 3'd4,
        C_CLEAR   = 3'd5
    } commit_st_e;
endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// valid marks the final step; quotient is that step's result.
module seq_divider #(
    parameter int W  = 14,
    parameter int QW = W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    input  logic [W-1:0]  divisor,
    output logic          busy,
    output logic          valid,
    output logic [QW-1:0] quotient
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_dvs;
    logic [CW-1:0] r_cnt;

    logic [W:0]    w_shift;
    logic [W-1:0]  w_diff;
    logic          w_ge;
    logic [W-1:0]  w_rem_nxt;
    logic [W-1:0]  w_quo_nxt;

    always_comb begin
        w_shift = {r_rem, r_quo[W-1]};
        w_ge    = (w_shift >= {1'b0, r_dvs});
        // true difference is below the divisor, so W bits suffice
        w_diff  = w_shift[W-1:0] - r_dvs;
        if (w_ge) begin
            w_rem_nxt = w_diff;
            w_quo_nxt = {r_quo[W-2:0], 1'b1};
        end else begin
            w_rem_nxt = w_shift[W-1:0];
            w_quo_nxt = {r_quo[W-2:0], 1'b0};
        end
    end

    assign busy     = (r_cnt != '0);
    assign valid    = busy && (r_cnt == CW'(1));
    assign quotient = (r_dvs == '0) ? '0 : w_quo_nxt[QW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_dvs <= divisor;
            r_cnt <= CW'(W);
        end else if (busy) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt - CW'(1);
        end
    end
endmodule

// File: rtl/record_commit_ctrl.sv
// Per-round statistics commit: two mode banks of sums, counts,
// bests and averages, averaged through one shared divider.
module record_commit_ctrl
    import typer_pkg::*;
#(
    parameter int         DATA_W    = DATA_W_DEF,
    parameter int         CNT_W     = CNT_W_DEF,
    parameter logic [2:0] ST_TYPING = GS_TYPING,
    parameter logic [2:0] ST_RESULT = GS_RESULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [2:0]        state,
    input  logic [DATA_W-1:0] wpm,
    input  logic [DATA_W-1:0] acc,
    input  logic              finish,
    input  logic              clear_req,
    output logic              busy,
    output logic              done,
    output logic              hist_full,
    output logic [DATA_W-1:0] wpm_best,
    output logic [DATA_W-1:0] wpm_average,
    output logic [DATA_W-1:0] acc_best,
    output logic [DATA_W-1:0] acc_average
);
    localparam int SUM_W = DATA_W + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [SUM_W-1:0]  wsum;
        logic [SUM_W-1:0]  asum;
        logic [CNT_W-1:0]  cnt;
        logic [DATA_W-1:0] wbest;
        logic [DATA_W-1:0] abest;
        logic [DATA_W-1:0] wavg;
        logic [DATA_W-1:0] aavg;
    } bank_t;

    commit_st_e        r_st;
    commit_st_e        w_st_nxt;
    bank_t             r_bank [2];
    bank_t             w_bank_nxt [2];
    logic [DATA_W-1:0] r_wpm;
    logic [DATA_W-1:0] r_acc;
    logic              r_mode;
    logic              r_lock;
    logic              r_clr_pend;
    logic              r_clr_bank;
    logic [DATA_W-1:0] r_wavg;
    logic [DATA_W-1:0] r_aavg;

    logic [DATA_W-1:0] r_o_wbest;
    logic [DATA_W-1:0] r_o_wavg;
    logic [DATA_W-1:0] r_o_abest;
    logic [DATA_W-1:0] r_o_aavg;
    logic              r_o_full;

    logic              w_accept;
    logic              w_sat;
    logic [CNT_W-1:0]  w_cnt_new;
    logic [SUM_W-1:0]  w_wsum_new;
    logic [SUM_W-1:0]  w_asum_new;
    logic              w_div_start;
    logic [SUM_W-1:0]  w_div_dvd;
    logic [SUM_W-1:0]  w_div_dvs;
    logic              w_div_busy;
    logic              w_div_valid;
    logic              w_div_done;
    logic [DATA_W-1:0] w_div_q;

    assign w_accept = (r_st == C_IDLE) && finish &&
                      (state == ST_RESULT) && !r_lock;

    // saturated banks keep their sums so the average stays meaningful
    assign w_sat      = (r_bank[r_mode].cnt == CNT_MAX);
    assign w_cnt_new  = w_sat ? r_bank[r_mode].cnt
                              : r_bank[r_mode].cnt + CNT_W'(1);
    assign w_wsum_new = w_sat ? r_bank[r_mode].wsum
                              : r_bank[r_mode].wsum + SUM_W'(r_wpm);
    assign w_asum_new = w_sat ? r_bank[r_mode].asum
                              : r_bank[r_mode].asum + SUM_W'(r_acc);

    assign w_div_done  = w_div_busy && w_div_valid;
    assign w_div_start = (r_st == C_LATCH) ||
                         ((r_st == C_DIV_WPM) && w_div_done);
    // the wpm divide starts before the bank update lands
    assign w_div_dvd = (r_st == C_LATCH) ? w_wsum_new
                                         : r_bank[r_mode].asum;
    assign w_div_dvs = (r_st == C_LATCH) ? SUM_W'(w_cnt_new)
                                         : SUM_W'(r_bank[r_mode].cnt);

    seq_divider #(
        .W  (SUM_W),
        .QW (DATA_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_div_start),
        .dividend (w_div_dvd),
        .divisor  (w_div_dvs),
        .busy     (w_div_busy),
        .valid    (w_div_valid),
        .quotient (w_div_q)
    );

    always_comb begin
        w_st_nxt = r_st;
        unique case (r_st)
            C_IDLE: begin
                if (w_accept)
                    w_st_nxt = C_LATCH;
                else if (clear_req || r_clr_pend)
                    w_st_nxt = C_CLEAR;
            end
            C_LATCH:   w_st_nxt = C_DIV_WPM;
            C_DIV_WPM: if (w_div_done) w_st_nxt = C_DIV_ACC;
            C_DIV_ACC: if (w_div_done) w_st_nxt = C_WRITE;
            C_WRITE:   w_st_nxt = C_IDLE;
            C_CLEAR:   w_st_nxt = C_IDLE;
            default:   w_st_nxt = C_IDLE;
        endcase
    end

    always_comb begin
        for (int b = 0; b < 2; b++) w_bank_nxt[b] = r_bank[b];
        unique case (r_st)
            C_LATCH: begin
                w_bank_nxt[r_mode].cnt  = w_cnt_new;
                w_bank_nxt[r_mode].wsum = w_wsum_new;
                w_bank_nxt[r_mode].asum = w_asum_new;
                if (r_wpm > r_bank[r_mode].wbest)
                    w_bank_nxt[r_mode].wbest = r_wpm;
                if (r_acc > r_bank[r_mode].abest)
                    w_bank_nxt[r_mode].abest = r_acc;
            end
            C_WRITE: begin
                w_bank_nxt[r_mode].wavg = r_wavg;
                w_bank_nxt[r_mode].aavg = r_aavg;
            end
            C_CLEAR: w_bank_nxt[r_clr_bank] = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st       <= C_IDLE;
            r_wpm      <= '0;
            r_acc      <= '0;
            r_mode     <= 1'b0;
            r_lock     <= 1'b0;
            r_clr_pend <= 1'b0;
            r_clr_bank <= 1'b0;
            r_wavg     <= '0;
            r_aavg     <= '0;
            for (int b = 0; b < 2; b++) r_bank[b] <= '0;
        end else begin
            r_st <= w_st_nxt;
            for (int b = 0; b < 2; b++) r_bank[b] <= w_bank_nxt[b];
            if (w_accept) begin
                r_wpm  <= wpm;
                r_acc  <= acc;
                r_mode <= mode;
                r_lock <= 1'b1;
            end else if (state == ST_TYPING) begin
                r_lock <= 1'b0;
            end
            if ((r_st == C_IDLE) && (w_st_nxt == C_CLEAR)) begin
                r_clr_pend <= 1'b0;
                r_clr_bank <= mode;
            end else if (clear_req) begin
                r_clr_pend <= 1'b1;
            end
            if ((r_st == C_DIV_WPM) && w_div_done) r_wavg <= w_div_q;
            if ((r_st == C_DIV_ACC) && w_div_done) r_aavg <= w_div_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o_wbest <= '0;
            r_o_wavg  <= '0;
            r_o_abest <= '0;
            r_o_aavg  <= '0;
            r_o_full  <= 1'b0;
        end else begin
            r_o_wbest <= w_bank_nxt[mode].wbest;
            r_o_wavg  <= w_bank_nxt[mode].wavg;
            r_o_abest <= w_bank_nxt[mode].abest;
            r_o_aavg  <= w_bank_nxt[mode].aavg;
            r_o_full  <= (w_bank_nxt[mode].cnt == CNT_MAX);
        end
    end

    assign busy        = (r_st != C_IDLE);
    assign done        = (r_st == C_WRITE);
    assign hist_full   = r_o_full;
    assign wpm_best    = r_o_wbest;
    assign wpm_average = r_o_wavg;
    assign acc_best    = r_o_abest;
    assign acc_average = r_o_aavg;
endmodule

// File: tb/tb_record_commit_ctrl.sv
// Bench for record_commit_ctrl: commit vectors, lock, saturation,
// mid-commit reset and deferred clear.
module tb_record_commit_ctrl;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic [2:0]    state;
    logic [DW-1:0] wpm;
    logic [DW-1:0] acc;
    logic          finish;
    logic          clear_req;
    logic          busy;
    logic          done;
    logic          hist_full;
    logic [DW-1:0] wpm_best;
    logic [DW-1:0] wpm_average;
    logic [DW-1:0] acc_best;
    logic [DW-1:0] acc_average;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int wb; int wa; int ab; int aa; int full;
    } exp_t;

    typedef struct {
        int   m; int w; int a;
        int   act; int actc;
        exp_t e; exp_t e2;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    record_commit_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .state       (state),
        .wpm         (wpm),
        .acc         (acc),
        .finish      (finish),
        .clear_req   (clear_req),
        .busy        (busy),
        .done        (done),
        .hist_full   (hist_full),
        .wpm_best    (wpm_best),
        .wpm_average (wpm_average),
        .acc_best    (acc_best),
        .acc_average (acc_average)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, ".wpm_best"}, int'(wpm_best), e.wb);
        chk({tag, ".wpm_average"}, int'(wpm_average), e.wa);
        chk({tag, ".acc_best"}, int'(acc_best), e.ab);
        chk({tag, ".acc_average"}, int'(acc_average), e.aa);
        chk({tag, ".hist_full"}, int'(hist_full), e.full);
    endtask

    // act: 0 none, 1 flip mode, 2 unlock+finish while busy,
    //      3 clear_req while busy, 4 reset at cycle actc
    task automatic run_commit(input string tag, input int m,
                              input int w, input int a,
                              input int act, input int actc,
                              input exp_t e);
        int   nb;
        int   nd;
        int   dc;
        exp_t x;
        state = 3'd2;
        @(negedge clk);
        state  = 3'd3;
        mode   = m[0];
        wpm    = DW'(w);
        acc    = DW'(a);
        finish = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        finish = 1'b0;
        nb = 0; nd = 0; dc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) nb++;
            if (done) begin nd++; dc = c; end
            if (act == 1 && c == actc) mode = ~m[0];
            if (act == 2 && c == actc) state = 3'd2;
            if (act == 2 && c == actc + 1) begin
                state = 3'd3; finish = 1'b1;
            end
            if (act == 2 && c == actc + 2) finish = 1'b0;
            if (act == 3 && c == actc) clear_req = 1'b1;
            if (act == 3 && c == actc + 1) clear_req = 1'b0;
            if (act == 4 && c == actc) rst = 1'b1;
            if (act == 4 && c == actc + 1) rst = 1'b0;
            @(negedge clk);
        end
        if (act == 4) begin
            chk({tag, ".busy_cycles"}, nb, actc);
            chk({tag, ".done_count"}, nd, 0);
            chk({tag, ".busy_after_rst"}, int'(busy), 0);
        end else begin
            chk({tag, ".busy_cycles"}, nb, (act == 3) ? 31 : 30);
            chk({tag, ".done_count"}, nd, 1);
            chk({tag, ".done_cycle"}, dc, 30);
        end
        if (sb.size() == 0) begin
            chk({tag, ".scoreboard"}, 0, 1);
        end else begin
            x = sb.pop_front();
            chk_out(tag, x);
        end
    endtask

    initial begin
        int   nb;
        int   nd;
        exp_t ez;
        exp_t es;
        ez = '{0, 0, 0, 0, 0};

        vecs[0] = '{0, 60, 95, 0, 0, '{60, 60, 95, 95, 0}, ez};
        vecs[1] = '{0, 41, 80, 2, 5, '{60, 50, 95, 87, 0}, ez};
        vecs[2] = '{1, 70, 90, 1, 5, '{60, 50, 95, 87, 0},
                    '{70, 70, 90, 90, 0}};
        vecs[3] = '{1, 65, 100, 0, 0, '{70, 67, 100, 95, 0}, ez};
        vecs[4] = '{1, 80, 60, 3, 5, ez, ez};
        vecs[5] = '{0, 90, 70, 4, 10, ez, ez};

        rst = 1'b1; mode = 1'b0; state = 3'd0;
        wpm = '0; acc = '0; finish = 1'b0; clear_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk_out("reset", ez);

        for (int i = 0; i < 6; i++) begin
            run_commit($sformatf("vec%0d", i), vecs[i].m, vecs[i].w,
                       vecs[i].a, vecs[i].act, vecs[i].actc, vecs[i].e);
            if (vecs[i].act == 1) begin
                mode = vecs[i].m[0];
                repeat (2) @(negedge clk);
                chk_out($sformatf("vec%0d.latched_bank", i), vecs[i].e2);
            end
            if (i == 0) begin
                // still locked: no visit to the typing state
                finish = 1'b1;
                @(negedge clk);
                finish = 1'b0;
                nb = 0;
                for (int c = 0; c < 6; c++) begin
                    if (busy) nb++;
                    @(negedge clk);
                end
                chk("relock.busy_cycles", nb, 0);
                chk_out("relock", vecs[0].e);
            end
        end

        for (int i = 1; i <= 16; i++) begin
            es = '{(i == 16) ? 200 : 100, 100, 50, 50,
                   (i >= 15) ? 1 : 0};
            run_commit($sformatf("sat%0d", i), 0,
                       (i == 16) ? 200 : 100, 50, 0, 0, es);
        end

        mode = 1'b0;
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        nb = 0; nd = 0;
        for (int c = 0; c < 5; c++) begin
            if (busy) nb++;
            if (done) nd++;
            @(negedge clk);
        end
        chk("idle_clear.busy_cycles", nb, 1);
        chk("idle_clear.done_count", nd, 0);
        chk_out("idle_clear", ez);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
